// File: rtl/tmr_neuron_sched_pkg.sv
// rtl/tmr_neuron_sched_pkg.sv - shared defaults, state encoding and helpers for the layer sequencer
package tmr_neuron_sched_pkg;

  localparam int DEF_M        = 8;
  localparam int DEF_N        = 16;
  localparam int DEF_CL       = 8;
  localparam int DEF_NNEUR    = 16;
  localparam int DEF_AW       = 4;
  localparam int DEF_NLAT     = 2;
  localparam int DEF_MAXRETRY = 3;
  localparam int DEF_TMO      = 15;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAITM  = 3'd2,
    S_SETTLE = 3'd3,
    S_CHECK  = 3'd4,
    S_EMIT   = 3'd5,
    S_FIN    = 3'd6,
    S_FLT    = 3'd7
  } sched_state_t;

  // Error counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/tmr_neuron_sched_timer.sv
// rtl/tmr_neuron_sched_timer.sv - clearable up-counter with terminal compare
module tmr_neuron_sched_timer #(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] limit,
  output logic [TW-1:0] count,
  output logic          hit
);

  // Restart from zero on load, otherwise count up one per cycle.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign hit = (count == limit);

endmodule

// File: rtl/tmr_neuron_sched.sv
// rtl/tmr_neuron_sched.sv - layer sequencer: fetch weights, wait on neuron, retry, emit H
module tmr_neuron_sched
  import tmr_neuron_sched_pkg::*;
#(
  parameter int M        = DEF_M,
  parameter int N        = DEF_N,
  parameter int CL       = DEF_CL,
  parameter int NNEUR    = DEF_NNEUR,
  parameter int AW       = DEF_AW,
  parameter int NLAT     = DEF_NLAT,
  parameter int MAXRETRY = DEF_MAXRETRY,
  parameter int TMO      = DEF_TMO
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                fault,
  output logic [7:0]          err_cnt,
  output logic                mem_rd,
  output logic [AW-1:0]       mem_addr,
  input  logic                mem_valid,
  input  logic [M*(N+CL)-1:0] mem_rdata,
  output logic [M*(N+CL)-1:0] Wcrc,
  input  logic                rfflag,
  input  logic                invalid,
  input  logic [N-1:0]        H,
  output logic                h_valid,
  output logic [N-1:0]        h_out,
  output logic [AW-1:0]       h_idx
);

  localparam int TW = $clog2(((TMO > NLAT) ? TMO : NLAT) + 1);
  localparam int RW = (MAXRETRY < 1) ? 1 : $clog2(MAXRETRY + 1);

  sched_state_t  state;
  sched_state_t  state_next;
  logic [AW-1:0] idx;
  logic [RW-1:0] retry;
  logic          retry_left;
  logic          last_idx;

  logic          timer_load;
  logic [TW-1:0] timer_limit;
  logic [TW-1:0] timer_count;
  logic          timer_hit;

  assign retry_left = (retry < RW'(MAXRETRY));
  assign last_idx   = (idx == AW'(NNEUR - 1));

  // The same counter measures the WAITM timeout and the SETTLE hold; it
  // restarts on every state change so each visit starts counting at zero.
  assign timer_load = (state_next != state);

  tmr_neuron_sched_timer #(
    .TW(TW)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .limit(timer_limit),
    .count(timer_count),
    .hit  (timer_hit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and the per-state strobes (memory request, busy, done).
  always_comb begin
    state_next  = state;
    mem_rd      = 1'b0;
    mem_addr    = '0;
    busy        = 1'b0;
    done        = 1'b0;
    timer_limit = TW'(TMO);
    case (state)
      S_IDLE: begin
        if (start) state_next = S_FETCH;
      end
      S_FETCH: begin
        busy       = 1'b1;
        mem_rd     = 1'b1;
        mem_addr   = idx;
        state_next = S_WAITM;
      end
      S_WAITM: begin
        busy = 1'b1;
        // A response arriving on the last allowed cycle still wins.
        if (mem_valid) begin
          state_next = S_SETTLE;
        end else if (timer_hit) begin
          state_next = S_FLT;
        end
      end
      S_SETTLE: begin
        busy        = 1'b1;
        timer_limit = TW'(NLAT - 1);
        if (timer_hit) state_next = S_CHECK;
      end
      S_CHECK: begin
        busy = 1'b1;
        // A bad weight CRC needs fresh data; a vote failure only needs the
        // neuron to recompute on the weights it already holds.
        if (rfflag) begin
          state_next = retry_left ? S_FETCH : S_FLT;
        end else if (invalid) begin
          state_next = retry_left ? S_SETTLE : S_FLT;
        end else begin
          state_next = S_EMIT;
        end
      end
      S_EMIT: begin
        busy       = 1'b1;
        state_next = last_idx ? S_FIN : S_FETCH;
      end
      S_FIN: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      S_FLT: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Layer bookkeeping: index, retry budget, error count, weight and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      retry   <= '0;
      err_cnt <= '0;
      fault   <= 1'b0;
      Wcrc    <= '0;
      h_valid <= 1'b0;
      h_out   <= '0;
      h_idx   <= '0;
    end else begin
      h_valid <= 1'b0;
      if (state_next == S_FLT) fault <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            idx     <= '0;
            retry   <= '0;
            err_cnt <= '0;
            fault   <= 1'b0;
          end
        end
        S_WAITM: begin
          if (mem_valid) Wcrc <= mem_rdata;
        end
        S_CHECK: begin
          if (rfflag || invalid) begin
            err_cnt <= sat_inc8(err_cnt);
            if (retry_left) retry <= retry + 1'b1;
          end else begin
            // H is settled here, so it is captured now and presented in EMIT.
            h_valid <= 1'b1;
            h_out   <= H;
            h_idx   <= idx;
          end
        end
        S_EMIT: begin
          retry <= '0;
          if (!last_idx) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tmr_neuron_sched.sv
// tb/tb_tmr_neuron_sched.sv - self-checking bench for the layer sequencer
module tb_tmr_neuron_sched;

  localparam int M    = 8;
  localparam int N    = 16;
  localparam int CL   = 8;
  localparam int LW   = N + CL;
  localparam int WW   = M * LW;
  localparam int NN   = 4;
  localparam int AW   = 4;
  localparam int NLAT = 2;
  localparam int MAXR = 3;
  localparam int TMO  = 15;
  localparam int MAXC = 600;

  localparam int K_CLEAN = 0;
  localparam int K_TRANS = 1;
  localparam int K_PERS  = 2;
  localparam int K_TMO   = 3;
  localparam int K_RAND  = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic          fault;
  logic [7:0]    err_cnt;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic          mem_valid;
  logic [WW-1:0] mem_rdata;
  logic [WW-1:0] Wcrc;
  logic          rfflag;
  logic          invalid;
  logic [N-1:0]  H;
  logic          h_valid;
  logic [N-1:0]  h_out;
  logic [AW-1:0] h_idx;

  tmr_neuron_sched #(
    .M(M), .N(N), .CL(CL), .NNEUR(NN), .AW(AW),
    .NLAT(NLAT), .MAXRETRY(MAXR), .TMO(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .fault(fault), .err_cnt(err_cnt), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata), .Wcrc(Wcrc),
    .rfflag(rfflag), .invalid(invalid), .H(H), .h_valid(h_valid),
    .h_out(h_out), .h_idx(h_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural neuron: CRC-8 (poly 0x07) per lane, H = sum of weights (X = 1.0).
  function automatic logic [7:0] crc8(input logic [15:0] w);
    logic [7:0] c;
    logic fb;
    c = 8'h00;
    for (int i = 15; i >= 0; i--) begin
      fb = c[7] ^ w[i];
      c = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction

  function automatic logic crc_ok(input logic [WW-1:0] wd);
    logic [LW-1:0] ln;
    for (int k = 0; k < M; k++) begin
      ln = wd[WW-1-LW*k -: LW];
      if (crc8(ln[LW-1:CL]) != ln[CL-1:0]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [N-1:0] h_of(input logic [WW-1:0] wd);
    logic [LW-1:0] ln;
    logic [N-1:0] s;
    s = '0;
    for (int k = 0; k < M; k++) begin
      ln = wd[WW-1-LW*k -: LW];
      s = s + ln[LW-1:CL];
    end
    return s;
  endfunction

  logic [N-1:0] h_pipe [NLAT];
  logic         rf_pipe[NLAT];
  always @(posedge clk) begin
    h_pipe[0]  <= h_of(Wcrc);
    rf_pipe[0] <= !crc_ok(Wcrc);
    for (int i = 1; i < NLAT; i++) begin
      h_pipe[i]  <= h_pipe[i-1];
      rf_pipe[i] <= rf_pipe[i-1];
    end
  end
  assign H      = h_pipe[NLAT-1];
  assign rfflag = rf_pipe[NLAT-1];

  logic [15:0] wtab[NN][M];

  function automatic logic [WW-1:0] make_word(input int idx, input bit corrupt, input int bitn);
    logic [WW-1:0] wd;
    logic [7:0] c;
    wd = '0;
    for (int k = 0; k < M; k++) begin
      c = crc8(wtab[idx][k]);
      if (corrupt && k == M - 1) c = c ^ (8'h01 << bitn);
      wd[WW-1-LW*k -: LW] = {wtab[idx][k], c};
    end
    return wd;
  endfunction

  // Expected per-cycle trace and per-cycle drive, relative to the start cycle.
  bit            e_rd[MAXC];
  logic [AW-1:0] e_addr[MAXC];
  bit            e_hv[MAXC];
  logic [N-1:0]  e_hout[MAXC];
  logic [AW-1:0] e_hidx[MAXC];
  bit            e_done[MAXC];
  bit            e_busy[MAXC];
  bit            e_fault[MAXC];
  logic [7:0]    e_err[MAXC];
  logic [WW-1:0] e_w[MAXC];
  bit            d_start[MAXC];
  bit            d_mv[MAXC];
  logic [WW-1:0] d_md[MAXC];
  bit            d_inv[MAXC];
  bit            in_waitm[MAXC];
  bit            is_chk[MAXC];
  bit            inc[MAXC];
  bit            wset[MAXC];
  logic [WW-1:0] wval[MAXC];
  int            run_len;

  bit            prev_fault;
  logic [7:0]    prev_err;
  logic [WW-1:0] prev_w;

  int n_total;
  int n_pass;

  task automatic chk(input string nm, input int c, input logic [WW-1:0] a, input logic [WW-1:0] e);
    n_total++;
    if (a === e) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, c, a, e);
  endtask

  // Walk the layer attempt by attempt using the documented per-state cycle costs.
  task automatic build(input int kind, input int lat);
    int t, chk_c, acc, retry, done_c;
    bit stop, fault_m, corrupt, inv, need_fetch, leave;
    logic [WW-1:0] cur;
    logic [7:0] err;
    logic [WW-1:0] w;
    for (int c = 0; c < MAXC; c++) begin
      e_rd[c] = 0; e_addr[c] = '0; e_hv[c] = 0; e_hout[c] = '0; e_hidx[c] = '0;
      e_done[c] = 0; e_busy[c] = 0; e_fault[c] = 0; e_err[c] = '0; e_w[c] = '0;
      d_start[c] = 0; d_mv[c] = 0; d_md[c] = '0; d_inv[c] = 0;
      in_waitm[c] = 0; is_chk[c] = 0; inc[c] = 0; wset[c] = 0; wval[c] = '0;
    end
    for (int i = 0; i < NN; i++)
      for (int k = 0; k < M; k++) wtab[i][k] = 16'($urandom);
    t = 1; stop = 0; fault_m = 0; done_c = 0; chk_c = 0; corrupt = 0; cur = '0;
    for (int idx = 0; idx < NN && !stop; idx++) begin
      retry = 0; need_fetch = 1; leave = 0;
      while (!leave) begin
        if (need_fetch) begin
          e_rd[t] = 1; e_addr[t] = AW'(idx);
          if (kind == K_TMO && idx == 0) begin
            for (int c = t + 1; c <= t + 1 + TMO; c++) in_waitm[c] = 1;
            done_c = t + 2 + TMO; fault_m = 1; stop = 1; leave = 1;
          end else begin
            acc = t + lat;
            for (int c = t + 1; c <= acc; c++) in_waitm[c] = 1;
            corrupt = (kind == K_TRANS && idx == 1 && retry == 0) ||
                      (kind == K_PERS && idx == 2) ||
                      (kind == K_RAND && $urandom_range(0, 3) == 0);
            cur = make_word(idx, corrupt, int'($urandom_range(0, 7)));
            d_mv[acc] = 1; d_md[acc] = cur; wset[acc+1] = 1; wval[acc+1] = cur;
            chk_c = acc + NLAT + 1;
          end
        end else begin
          chk_c = chk_c + NLAT + 1;
        end
        if (!leave) begin
          is_chk[chk_c] = 1;
          inv = (kind == K_RAND) && ($urandom_range(0, 4) == 0);
          if (corrupt || inv) begin
            inc[chk_c+1] = 1;
            if (retry < MAXR) begin
              retry++;
              need_fetch = corrupt;
              t = chk_c + 1;
            end else begin
              done_c = chk_c + 1; fault_m = 1; stop = 1; leave = 1;
            end
            if (!corrupt) d_inv[chk_c] = 1;
          end else begin
            e_hv[chk_c+1] = 1; e_hidx[chk_c+1] = AW'(idx); e_hout[chk_c+1] = h_of(cur);
            t = chk_c + 2; leave = 1;
          end
        end
      end
    end
    if (!stop) done_c = t;
    run_len = done_c + 4;
    err = prev_err; w = prev_w;
    for (int c = 0; c < run_len; c++) begin
      if (c == 1) err = 8'h00;
      if (inc[c] && err != 8'hFF) err = err + 8'd1;
      if (wset[c]) w = wval[c];
      e_err[c]   = err;
      e_w[c]     = w;
      e_done[c]  = (c == done_c);
      e_busy[c]  = (c >= 1 && c < done_c);
      e_fault[c] = (c == 0) ? prev_fault : ((c >= done_c) ? fault_m : 1'b0);
      if (!in_waitm[c] && $urandom_range(0, 3) == 0) begin
        d_mv[c] = 1;
        d_md[c] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
      if (!is_chk[c] && $urandom_range(0, 2) == 0) d_inv[c] = 1;
      d_start[c] = (c == 0) || (c >= 1 && c <= done_c && $urandom_range(0, 7) == 0);
    end
    prev_fault = fault_m;
    prev_err   = e_err[done_c];
    prev_w     = e_w[run_len-1];
  endtask

  task automatic check_zero(input int c);
    chk("rst_busy", c, WW'(busy), '0);
    chk("rst_done", c, WW'(done), '0);
    chk("rst_fault", c, WW'(fault), '0);
    chk("rst_err_cnt", c, WW'(err_cnt), '0);
    chk("rst_mem_rd", c, WW'(mem_rd), '0);
    chk("rst_mem_addr", c, WW'(mem_addr), '0);
    chk("rst_wcrc", c, Wcrc, '0);
    chk("rst_h_valid", c, WW'(h_valid), '0);
    chk("rst_h_out", c, WW'(h_out), '0);
    chk("rst_h_idx", c, WW'(h_idx), '0);
  endtask

  int dcyc, hv_cnt, rdcnt[16];
  logic [7:0] err_obs;

  // Drive one planned run; compare every output on every cycle at the falling edge.
  task automatic run(input int rst_at);
    int last;
    dcyc = -1; hv_cnt = 0; err_obs = '0;
    for (int a = 0; a < 16; a++) rdcnt[a] = 0;
    last = (rst_at >= 0) ? rst_at : run_len - 1;
    for (int c = 0; c <= last; c++) begin
      @(posedge clk); #1;
      rst = (c == rst_at); start = d_start[c]; mem_valid = d_mv[c];
      mem_rdata = d_md[c]; invalid = d_inv[c];
      @(negedge clk);
      chk("busy", c, WW'(busy), WW'(e_busy[c]));
      chk("done", c, WW'(done), WW'(e_done[c]));
      chk("fault", c, WW'(fault), WW'(e_fault[c]));
      chk("err_cnt", c, WW'(err_cnt), WW'(e_err[c]));
      chk("mem_rd", c, WW'(mem_rd), WW'(e_rd[c]));
      if (e_rd[c]) chk("mem_addr", c, WW'(mem_addr), WW'(e_addr[c]));
      chk("h_valid", c, WW'(h_valid), WW'(e_hv[c]));
      if (e_hv[c]) begin
        chk("h_idx", c, WW'(h_idx), WW'(e_hidx[c]));
        chk("h_out", c, WW'(h_out), WW'(e_hout[c]));
      end
      chk("wcrc", c, Wcrc, e_w[c]);
      if (done && dcyc < 0) begin dcyc = c; err_obs = err_cnt; end
      if (mem_rd) rdcnt[mem_addr]++;
      if (h_valid) hv_cnt++;
    end
    if (rst_at >= 0) begin
      @(posedge clk); #1;
      rst = 0; start = 0; mem_valid = 0; invalid = 0;
      @(negedge clk);
      check_zero(rst_at + 1);
      prev_fault = 0; prev_err = '0; prev_w = '0;
    end
  endtask

  initial begin
    n_total = 0; n_pass = 0;
    prev_fault = 0; prev_err = '0; prev_w = '0;
    rst = 1; start = 0; mem_valid = 0; mem_rdata = '0; invalid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero(0);

    build(K_CLEAN, 2); run(-1);
    chk("clean_done_cycle", dcyc, WW'(dcyc), WW'(29));
    chk("clean_h_count", 0, WW'(hv_cnt), WW'(4));
    chk("clean_err", 0, WW'(err_obs), WW'(0));

    build(K_TRANS, 2); run(-1);
    chk("trans_reads_addr1", 0, WW'(rdcnt[1]), WW'(2));
    chk("trans_err", 0, WW'(err_obs), WW'(1));
    chk("trans_h_count", 0, WW'(hv_cnt), WW'(4));

    build(K_PERS, 2); run(-1);
    chk("pers_reads_addr2", 0, WW'(rdcnt[2]), WW'(4));
    chk("pers_err", 0, WW'(err_obs), WW'(4));
    chk("pers_h_count", 0, WW'(hv_cnt), WW'(2));

    build(K_CLEAN, 2); run(-1);

    build(K_TMO, 2); run(-1);
    chk("tmo_done_cycle", 0, WW'(dcyc), WW'(18));

    build(K_CLEAN, 2); run(18);
    build(K_CLEAN, 2); run(-1);
    chk("post_rst_h_count", 0, WW'(hv_cnt), WW'(4));

    for (int r = 0; r < 14; r++) begin
      build(K_RAND, ($urandom_range(0, 5) == 0) ? TMO + 1 : int'($urandom_range(1, 4)));
      run(-1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
